// File: rtl/dcache_controller_if.sv
// dcache_controller_if
// Bundles the two buses of the data cache controller:
//   CPU side    : memread, memwrite, funct3, address, writedata -> cache
//                 readdata, busywait                            <- cache
//   memory side : mem_read, mem_write, mem_address, mem_writedata <- cache
//                 mem_readdata, mem_busywait                       -> cache
// Modports:
//   slave  : the cache controller itself
//   master : the surrounding system (CPU memory stage plus main memory)
interface dcache_controller_if;
    logic         memread;
    logic         memwrite;
    logic [2:0]   funct3;
    logic [31:0]  address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         busywait;

    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    modport slave (
        input  memread, memwrite, funct3, address, writedata,
        output readdata, busywait,
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport master (
        output memread, memwrite, funct3, address, writedata,
        input  readdata, busywait,
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );
endinterface

// File: rtl/dcache_controller.sv
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache between the CPU
// memory stage and main data memory. Lines are 16 bytes (4 words).
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dcache_controller_if.slave carrying the CPU request/response
//           signals and the 128-bit block interface to main memory
// Loads return byte/half/word data sign- or zero-extended by funct3.
// A hit completes with no stall; a miss stalls via busywait while the
// victim is written back (if dirty) and the new block is fetched.
module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    dcache_controller_if.slave bus
);
    localparam int BLOCK_BYTES = 16;
    localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
    localparam int NUM_LINES   = 1 << INDEX_BITS;
    localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;
    localparam int BLK_BITS    = 32 - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    state_t state;

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_BITS-1:0]  tag_array  [NUM_LINES];
    logic [127:0]         data_array [NUM_LINES];

    // Block address of the miss being serviced, latched so the transfer
    // still completes correctly if the CPU drops its request mid-miss.
    logic [BLK_BITS-1:0]   miss_block;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;

    logic                  request;
    logic                  is_write;
    logic [3:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic [127:0]          line;
    logic [127:0]          merged_line;
    logic [127:0]          wdata_rep;
    logic [15:0]           byte_en;
    logic [31:0]           word_data;
    logic [15:0]           half_data;
    logic [7:0]            byte_data;
    logic [31:0]           load_data;

    assign request    = bus.memread | bus.memwrite;
    assign is_write   = bus.memwrite;
    assign offset     = bus.address[OFFSET_BITS-1:0];
    assign index      = bus.address[OFFSET_BITS +: INDEX_BITS];
    assign tag        = bus.address[31 -: TAG_BITS];
    assign hit        = valid[index] && (tag_array[index] == tag);
    assign line       = data_array[index];
    assign miss_index = miss_block[INDEX_BITS-1:0];
    assign miss_tag   = miss_block[BLK_BITS-1 -: TAG_BITS];

    // Stall whenever a request cannot be finished this cycle. Gated by
    // reset so the pipeline is released while the cache is held in reset.
    assign bus.busywait = rst_n & request & ~((state == IDLE) & hit);

    // Load path: select the addressed byte/half/word from the line and
    // extend it. Low address bits below the access size are ignored.
    always_comb begin
        word_data = line[{offset[3:2], 5'b0} +: 32];
        half_data = line[{offset[3:1], 4'b0} +: 16];
        byte_data = line[{offset, 3'b0} +: 8];
        case (bus.funct3)
            3'b000:  load_data = {{24{byte_data[7]}}, byte_data};
            3'b001:  load_data = {{16{half_data[15]}}, half_data};
            3'b100:  load_data = {24'b0, byte_data};
            3'b101:  load_data = {16'b0, half_data};
            default: load_data = word_data;
        endcase
        bus.readdata = hit ? load_data : 32'b0;
    end

    // Store path: replicate the store data across the line and build a
    // byte-enable mask, so only the addressed bytes are replaced.
    always_comb begin
        case (bus.funct3[1:0])
            2'b00: begin
                byte_en   = 16'h0001 << offset;
                wdata_rep = {16{bus.writedata[7:0]}};
            end
            2'b01: begin
                byte_en   = 16'h0003 << {offset[3:1], 1'b0};
                wdata_rep = {8{bus.writedata[15:0]}};
            end
            default: begin
                byte_en   = 16'h000F << {offset[3:2], 2'b00};
                wdata_rep = {4{bus.writedata}};
            end
        endcase
        for (int i = 0; i < 16; i++) begin
            merged_line[i*8 +: 8] = byte_en[i] ? wdata_rep[i*8 +: 8] : line[i*8 +: 8];
        end
    end

    // Data and tag arrays carry no reset; their contents only matter once
    // the valid bit is set. The fetched block is captured on the cycle the
    // memory completes, so the memory need not hold its read data after
    // the handshake; the line becomes valid one cycle later in UPDATE.
    always_ff @(posedge clk) begin
        if (state == FETCH && !bus.mem_busywait) begin
            data_array[miss_index] <= bus.mem_readdata;
            tag_array[miss_index]  <= miss_tag;
        end else if (state == IDLE && request && hit && is_write) begin
            data_array[index] <= merged_line;
        end
    end

    // Miss-handling state machine with registered memory-side outputs.
    // A reset during any state abandons the transfer without write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            valid             <= '0;
            dirty             <= '0;
            miss_block        <= '0;
            bus.mem_read      <= 1'b0;
            bus.mem_write     <= 1'b0;
            bus.mem_address   <= '0;
            bus.mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        miss_block <= bus.address[31:OFFSET_BITS];
                        if (valid[index] && dirty[index]) begin
                            state             <= WRITEBACK;
                            bus.mem_write     <= 1'b1;
                            bus.mem_address   <= {tag_array[index], index};
                            bus.mem_writedata <= line;
                        end else begin
                            state           <= FETCH;
                            bus.mem_read    <= 1'b1;
                            bus.mem_address <= bus.address[31:OFFSET_BITS];
                        end
                    end else if (request && hit && is_write) begin
                        dirty[index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (!bus.mem_busywait) begin
                        state           <= FETCH;
                        bus.mem_write   <= 1'b0;
                        bus.mem_read    <= 1'b1;
                        bus.mem_address <= miss_block;
                    end
                end
                FETCH: begin
                    if (!bus.mem_busywait) begin
                        state        <= UPDATE;
                        bus.mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    valid[miss_index] <= 1'b1;
                    dirty[miss_index] <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller
// Self-checking bench for dcache_controller. A behavioural main memory with
// a fixed 5-cycle latency answers block requests and logs every completed
// transfer. A flat byte-level golden memory gives the value every load must
// return; expected load values are queued when a load is issued and popped
// when the cache releases busywait.
module tb_dcache_controller;
    localparam int MEM_LAT = 5;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk;
    logic rst_n;

    dcache_controller_if bus ();

    dcache_controller #(.INDEX_BITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0]  exp_q [$];
    logic [7:0]   golden [1024];
    logic [127:0] mem_store [64];
    bit           mem_init_done;
    int           mem_cnt;
    int           overlap_cnt;
    logic [28:0]  txn_q [$];
    logic [127:0] txn_data_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Initial memory image: block 4 holds the known pattern, others a
    // pattern derived from the block address with mixed high bits.
    function automatic logic [127:0] blk_init(input int ba);
        logic [27:0] b;
        b = ba[27:0];
        if (ba == 4)
            return {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        return {{b, 4'h3} ^ 32'h9C5A3E71, {b, 4'h2} ^ 32'h13F0A5C8,
                {b, 4'h1} ^ 32'hE7266B94, {b, 4'h0} ^ 32'h5A8D0C3F};
    endfunction

    function automatic logic [127:0] golden_block(input int ba);
        logic [127:0] blk;
        for (int j = 0; j < 16; j++) blk[j*8 +: 8] = golden[ba*16 + j];
        return blk;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        int wb;
        int hb;
        int bb;
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  by;
        wb = int'({a[9:2], 2'b00});
        hb = int'({a[9:1], 1'b0});
        bb = int'(a[9:0]);
        w  = {golden[wb+3], golden[wb+2], golden[wb+1], golden[wb]};
        h  = {golden[hb+1], golden[hb]};
        by = golden[bb];
        case (f3)
            F_B:     return {{24{by[7]}}, by};
            F_H:     return {{16{h[15]}}, h};
            F_BU:    return {24'b0, by};
            F_HU:    return {16'b0, h};
            default: return w;
        endcase
    endfunction

    task automatic golden_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int base;
        if (f3 == F_B) begin
            golden[int'(a[9:0])] = wd[7:0];
        end else if (f3 == F_H) begin
            base = int'({a[9:1], 1'b0});
            golden[base]   = wd[7:0];
            golden[base+1] = wd[15:8];
        end else begin
            base = int'({a[9:2], 2'b00});
            golden[base]   = wd[7:0];
            golden[base+1] = wd[15:8];
            golden[base+2] = wd[23:16];
            golden[base+3] = wd[31:24];
        end
    endtask

    // Main memory model: busywait is high for MEM_LAT-1 cycles of a
    // request and the transfer completes in the cycle it is low.
    assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (mem_cnt != MEM_LAT - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_cnt <= 0;
        else if (bus.mem_read | bus.mem_write)
            mem_cnt <= (mem_cnt == MEM_LAT - 1) ? 0 : mem_cnt + 1;
        else
            mem_cnt <= 0;
    end

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem_store[i] <= blk_init(i);
            mem_init_done <= 1'b1;
        end else if (rst_n && (bus.mem_read | bus.mem_write) && !bus.mem_busywait) begin
            if (bus.mem_write) begin
                mem_store[bus.mem_address[5:0]] <= bus.mem_writedata;
                txn_q.push_back({1'b1, bus.mem_address});
                txn_data_q.push_back(bus.mem_writedata);
            end else begin
                txn_q.push_back({1'b0, bus.mem_address});
                txn_data_q.push_back(128'b0);
            end
        end
        if (bus.mem_read) bus.mem_readdata <= mem_store[bus.mem_address[5:0]];
    end

    always @(negedge clk) begin
        if (bus.mem_read && bus.mem_write) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic drive_idle();
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.funct3    = F_W;
        bus.address   = 32'b0;
        bus.writedata = 32'b0;
    endtask

    // Issue one CPU access and hold it until busywait falls; returns the
    // load data seen in the completing cycle and the number of stall cycles.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rdata, output int stalls, output bit timeout);
        @(negedge clk);
        bus.memread   = rd;
        bus.memwrite  = wr;
        bus.funct3    = f3;
        bus.address   = addr;
        bus.writedata = wd;
        #1;
        stalls  = 0;
        timeout = 1'b0;
        while (bus.busywait === 1'b1) begin
            stalls++;
            if (stalls > 200) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        rdata = bus.readdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busywait !== 1'b0) begin errors++; $display("[TB] FAIL reset_busywait: got %b expected 0", bus.busywait); end
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_read: got %b expected 0", bus.mem_read); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_write: got %b expected 0", bus.mem_write); end
        checks++; if (bus.mem_address !== 28'h0) begin errors++; $display("[TB] FAIL reset_mem_address: got %h expected 0", bus.mem_address); end
        checks++; if (bus.mem_writedata !== 128'h0) begin errors++; $display("[TB] FAIL reset_mem_writedata: got %h expected 0", bus.mem_writedata); end
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_readdata: got %h expected 0", bus.readdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_miss();
        logic [31:0] rdata;
        logic [31:0] expv;
        int stalls;
        bit to;
        int start;
        start = txn_q.size();
        exp_q.push_back(exp_load(F_W, 32'h40));
        do_access(1'b1, 1'b0, F_W, 32'h40, 32'h0, rdata, stalls, to);
        expv = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("[TB] FAIL clean_miss_timeout: busywait stuck high"); end
        checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL clean_miss_data: got %h expected %h", rdata, expv); end
        checks++; if (stalls != 7) begin errors++; $display("[TB] FAIL clean_miss_stalls: got %0d expected 7", stalls); end
        checks++; if (txn_q.size() != start + 1) begin errors++; $display("[TB] FAIL clean_miss_txn_count: got %0d expected %0d", txn_q.size(), start + 1); end
        else begin
            checks++; if (txn_q[start] !== {1'b0, 28'h4}) begin errors++; $display("[TB] FAIL clean_miss_read_addr: got %h expected %h", txn_q[start], {1'b0, 28'h4}); end
        end
    endtask

    task automatic test_byte_loads();
        logic [31:0] rdata;
        logic [31:0] expv;
        int stalls;
        bit to;
        do_access(1'b0, 1'b1, F_B, 32'h41, 32'h0000_0080, rdata, stalls, to);
        golden_store(F_B, 32'h41, 32'h0000_0080);
        checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL sb_hit_stalls: got %0d expected 0", stalls); end
        exp_q.push_back(exp_load(F_B, 32'h41));
        do_access(1'b1, 1'b0, F_B, 32'h41, 32'h0, rdata, stalls, to);
        expv = exp_q.pop_front();
        checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL lb_sign: got %h expected %h", rdata, expv); end
        checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL lb_stalls: got %0d expected 0", stalls); end
        exp_q.push_back(exp_load(F_BU, 32'h41));
        do_access(1'b1, 1'b0, F_BU, 32'h41, 32'h0, rdata, stalls, to);
        expv = exp_q.pop_front();
        checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL lbu_zero: got %h expected %h", rdata, expv); end
        checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL lbu_stalls: got %0d expected 0", stalls); end
    endtask

    task automatic test_store_merge();
        logic [31:0] rdata;
        logic [31:0] expv;
        int stalls;
        bit to;
        do_access(1'b0, 1'b1, F_H, 32'h42, 32'h0000_BEEF, rdata, stalls, to);
        golden_store(F_H, 32'h42, 32'h0000_BEEF);
        checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL sh_hit_stalls: got %0d expected 0", stalls); end
        exp_q.push_back(exp_load(F_W, 32'h40));
        do_access(1'b1, 1'b0, F_W, 32'h40, 32'h0, rdata, stalls, to);
        expv = exp_q.pop_front();
        checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL sh_merge_word: got %h expected %h", rdata, expv); end
        checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL lw_after_sh_stalls: got %0d expected 0", stalls); end
        exp_q.push_back(exp_load(F_HU, 32'h43));
        do_access(1'b1, 1'b0, F_HU, 32'h43, 32'h0, rdata, stalls, to);
        expv = exp_q.pop_front();
        checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL lhu_odd_addr: got %h expected %h", rdata, expv); end
    endtask

    task automatic test_dirty_miss();
        logic [31:0]  rdata;
        logic [31:0]  expv;
        logic [127:0] victim;
        int stalls;
        bit to;
        int start;
        int ov;
        start  = txn_q.size();
        ov     = overlap_cnt;
        victim = golden_block(4);
        exp_q.push_back(exp_load(F_W, 32'h140));
        do_access(1'b1, 1'b0, F_W, 32'h140, 32'h0, rdata, stalls, to);
        expv = exp_q.pop_front();
        checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL dirty_miss_data: got %h expected %h", rdata, expv); end
        checks++; if (stalls != 12) begin errors++; $display("[TB] FAIL dirty_miss_stalls: got %0d expected 12", stalls); end
        checks++; if (overlap_cnt != ov) begin errors++; $display("[TB] FAIL rd_wr_overlap: got %0d overlap cycles expected 0", overlap_cnt - ov); end
        checks++; if (txn_q.size() != start + 2) begin errors++; $display("[TB] FAIL dirty_miss_txn_count: got %0d expected %0d", txn_q.size(), start + 2); end
        else begin
            checks++; if (txn_q[start] !== {1'b1, 28'h4}) begin errors++; $display("[TB] FAIL wb_addr: got %h expected %h", txn_q[start], {1'b1, 28'h4}); end
            checks++; if (txn_data_q[start] !== victim) begin errors++; $display("[TB] FAIL wb_data: got %h expected %h", txn_data_q[start], victim); end
            checks++; if (txn_q[start+1] !== {1'b0, 28'h14}) begin errors++; $display("[TB] FAIL refill_addr: got %h expected %h", txn_q[start+1], {1'b0, 28'h14}); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] rdata;
        logic [31:0] expv;
        int stalls;
        bit to;
        int n;
        int start;
        @(negedge clk);
        bus.memread  = 1'b1;
        bus.memwrite = 1'b0;
        bus.funct3   = F_W;
        bus.address  = 32'h40;
        n = 0;
        while (bus.mem_read !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 20) begin errors++; $display("[TB] FAIL fetch_start: mem_read got %b expected 1", bus.mem_read); end
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_mem_read: got %b expected 0", bus.mem_read); end
        checks++; if (bus.busywait !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busywait: got %b expected 0", bus.busywait); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_mem_write: got %b expected 0", bus.mem_write); end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        start = txn_q.size();
        exp_q.push_back(exp_load(F_W, 32'h40));
        do_access(1'b1, 1'b0, F_W, 32'h40, 32'h0, rdata, stalls, to);
        expv = exp_q.pop_front();
        checks++; if (stalls != 7) begin errors++; $display("[TB] FAIL post_rst_miss_stalls: got %0d expected 7", stalls); end
        checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL post_rst_data: got %h expected %h", rdata, expv); end
        checks++; if (txn_q.size() != start + 1) begin errors++; $display("[TB] FAIL post_rst_txn_count: got %0d expected %0d", txn_q.size(), start + 1); end
    endtask

    task automatic test_read_write_both();
        logic [31:0] rdata;
        logic [31:0] expv;
        int stalls;
        bit to;
        do_access(1'b1, 1'b1, F_W, 32'h40, 32'hCAFEF00D, rdata, stalls, to);
        golden_store(F_W, 32'h40, 32'hCAFEF00D);
        checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL both_hit_stalls: got %0d expected 0", stalls); end
        exp_q.push_back(exp_load(F_W, 32'h40));
        do_access(1'b1, 1'b0, F_W, 32'h40, 32'h0, rdata, stalls, to);
        expv = exp_q.pop_front();
        checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL both_as_write: got %h expected %h", rdata, expv); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdata;
        logic [31:0] expv;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic        rd;
        int stalls;
        bit to;
        bit is_st;
        int sel;
        for (int k = 0; k < 80; k++) begin
            is_st = ($urandom_range(0, 2) == 0);
            addr  = 32'($urandom_range(0, 3) * 128 + $urandom_range(0, 7) * 16 + $urandom_range(0, 15));
            wd    = $urandom;
            if (is_st) begin
                sel = int'($urandom_range(0, 2));
                f3  = (sel == 0) ? F_B : ((sel == 1) ? F_H : F_W);
                rd  = 1'($urandom_range(0, 1));
                do_access(rd, 1'b1, f3, addr, wd, rdata, stalls, to);
                golden_store(f3, addr, wd);
            end else begin
                f3 = 3'($urandom_range(0, 7));
                exp_q.push_back(exp_load(f3, addr));
                do_access(1'b1, 1'b0, f3, addr, 32'h0, rdata, stalls, to);
                expv = exp_q.pop_front();
                checks++; if (rdata !== expv) begin errors++; $display("[TB] FAIL b2b_load_%0d: addr %h f3 %b got %h expected %h", k, addr, f3, rdata, expv); end
            end
            checks++; if (to || !(stalls == 0 || stalls == 7 || stalls == 12)) begin errors++; $display("[TB] FAIL b2b_stalls_%0d: got %0d expected 0, 7 or 12", k, stalls); end
        end
        drive_idle();
    endtask

    initial begin
        for (int ba = 0; ba < 64; ba++) begin
            logic [127:0] blk;
            blk = blk_init(ba);
            for (int j = 0; j < 16; j++) golden[ba*16 + j] = blk[j*8 +: 8];
        end
        test_reset();
        test_clean_miss();
        test_byte_loads();
        test_store_merge();
        test_dirty_miss();
        test_reset_mid_fetch();
        test_read_write_both();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
